bcd_display_scan: RTL and testbench
===================================

// Module: bcd_display_scan
// PURPOSE
//   Consumes the packed 8-digit BCD word and sign flag produced by the data-output
//   stage and drives a time-multiplexed 8-digit 7-segment display.
//   Double-buffered: a new value is accepted at any time but shown only from the start
//   of the next full scan frame, so a frame never mixes two values.
// PARAMETERS
//   CLK_DIV        50000  clock cycles per digit slot (>=2)
//   SEG_ACTIVE_LOW 1      1: an_out/seg_out/dp_out active-low; 0: active-high
// PORTS
//   clock       in   1   system clock, all logic on posedge
//   reset       in   1   synchronous, active-high
//   load        in   1   1-cycle strobe: capture bcd_in/neg_in into pending buffer
//   bcd_in      in   32  packed BCD, digit k = bcd_in[4k+3:4k], digit 0 = units
//   neg_in      in   1   value is negative
//   an_out      out  8   one-hot digit enable, bit k = digit k
//   seg_out     out  7   segments {g,f,e,d,c,b,a}
//   dp_out      out  1   decimal point of the enabled digit
//   frame_done  out  1   1-cycle pulse when digit 7 slot ends
//   bcd_err     out  1   sticky: a displayed nibble was > 9
// BEHAVIOUR
//   Reset: all anodes, segments and dp inactive; frame_done=0, bcd_err=0.
//   Reset also clears prescaler, digit index (0), active and pending buffers, and pending_valid.
//   Reset mid-frame aborts the scan immediately; any pending value is discarded.
//   Prescaler: counts 0..CLK_DIV-1 and wraps. tick=1 on the cycle it equals CLK_DIV-1.
//   Digit index: 0..7; on tick, index+1; at 7 it wraps to 0.
//   load: pending <= {neg_in,bcd_in}, pending_valid <= 1.
//   A second load before the swap overwrites pending (last value wins).
//   Swap: on tick with index==7, if pending_valid, active <= pending and pending_valid <= 0.
//     frame_done=1 in that same cycle, registered, visible 1 cycle later.
//   load in the swap cycle: the swap uses the old pending value.
//     The new value stays pending for the next frame.
//   Outputs are registered from index/active: an_out/seg_out change 1 cycle after index changes.
//   Decode: 0-9 standard patterns.
//     Nibble 10-15 shows "-" (g only) and sets bcd_err until reset.
//   Sign: minus pattern is g only; it is never drawn over a value digit.
// CONFIGURATION
//   `LZ_BLANK_EN defined:
//     MSD = highest nonzero digit (0 if the value is 0).
//     Digits above MSD blanked: anode still scanned, segments off.
//     If neg and MSD<7, digit MSD+1 shows minus.
//     If neg and MSD==7, dp lit on digit 7.
//   `LZ_BLANK_EN undefined: all 8 digits always shown, including zeros.
//     neg shown only as dp lit on digit 7.
//   Invalid nibbles count as nonzero for the MSD search.
// TESTING (CLK_DIV=4, SEG_ACTIVE_LOW=1)
//   1. Reset held 3 cycles, then released.
//      -> an_out=8'hFF, seg_out=7'h7F, dp_out=1 during reset.
//      -> First anode 8'hFE appears; slots are 4 cycles apart.
//   2. load bcd_in=32'h00001234, neg_in=0, then wait one full frame.
//      -> Digits 0..3 show 4,3,2,1; digit 0 seg_out=7'b0011001.
//      -> With LZ_BLANK_EN, digits 4-7 blanked (7'h7F).
//   3. load 32'h00000042, neg_in=1, with LZ_BLANK_EN.
//      -> Digit 2 seg_out=7'b0111111 (minus).
//      -> Without the macro, dp_out=0 on digit 7 only.
//   4. load 32'h11111111 mid-frame at index 3.
//      -> Remaining slots of the frame show the old value.
//      -> New value appears at the index-0 slot after frame_done.
//   5. Two loads A then B before the swap.
//      -> Only B is ever displayed.
//   6. load 32'h0000000C.
//      -> Digit 0 shows "-" and bcd_err=1.
//      -> bcd_err stays 1 after loading a valid value; it clears only on reset.

Source files
------------

// File: rtl/bcd_display_scan.sv
// bcd_display_scan: double-buffered 8-digit BCD 7-segment scanner; optional leading-zero
// blanking with a floating minus sign is enabled by defining LZ_BLANK_EN.
module bcd_display_scan #(
    parameter int unsigned CLK_DIV = 50000,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        load,
    input  logic [31:0] bcd_in,
    input  logic        neg_in,
    output logic [7:0]  an_out,
    output logic [6:0]  seg_out,
    output logic        dp_out,
    output logic        frame_done,
    output logic        bcd_err
);
    localparam int PW = $clog2(CLK_DIV);
    logic [PW-1:0] cnt;
    logic [2:0] idx;
    logic [32:0] active, pending;
    logic pvalid, tick, swap, blank, minus, dp, err;
    logic [3:0] nib;
    logic [6:0] seg;
    function automatic logic [6:0] dec(input logic [3:0] d);
        case (d)
            4'd0: dec = 7'h3F;
            4'd1: dec = 7'h06;
            4'd2: dec = 7'h5B;
            4'd3: dec = 7'h4F;
            4'd4: dec = 7'h66;
            4'd5: dec = 7'h6D;
            4'd6: dec = 7'h7D;
            4'd7: dec = 7'h07;
            4'd8: dec = 7'h7F;
            4'd9: dec = 7'h6F;
            default: dec = 7'h40;
        endcase
    endfunction
    assign tick = cnt == PW'(CLK_DIV - 1);
    assign swap = tick && idx == 3'd7;
    assign nib = active[{idx, 2'b00} +: 4];
`ifdef LZ_BLANK_EN
    logic [2:0] msd;
    // invalid nibbles are nonzero, so they always sit at or below the MSD
    always_comb begin
        msd = 3'd0;
        for (int i = 1; i < 8; i++)
            if (active[i*4 +: 4] != 4'd0) msd = 3'(i);
    end
    assign blank = idx > msd;
    assign minus = active[32] && msd != 3'd7 && idx == msd + 3'd1;
    assign dp = active[32] && msd == 3'd7 && idx == 3'd7;
`else
    assign blank = 1'b0;
    assign minus = 1'b0;
    assign dp = active[32] && idx == 3'd7;
`endif
    assign seg = minus ? 7'h40 : blank ? 7'h00 : dec(nib);
    assign err = !blank && nib > 4'd9;
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt <= '0;
            idx <= 3'd0;
            active <= '0;
            pending <= '0;
            pvalid <= 1'b0;
            an_out <= {8{SEG_ACTIVE_LOW}};
            seg_out <= {7{SEG_ACTIVE_LOW}};
            dp_out <= SEG_ACTIVE_LOW;
            frame_done <= 1'b0;
            bcd_err <= 1'b0;
        end else begin
            cnt <= tick ? '0 : cnt + 1'b1;
            idx <= tick ? idx + 3'd1 : idx;
            if (swap && pvalid) active <= pending;
            if (load) pending <= {neg_in, bcd_in};
            pvalid <= load || (pvalid && !swap);
            frame_done <= swap;
            an_out <= {8{SEG_ACTIVE_LOW}} ^ (8'd1 << idx);
            seg_out <= {7{SEG_ACTIVE_LOW}} ^ seg;
            dp_out <= SEG_ACTIVE_LOW ^ dp;
            bcd_err <= bcd_err | err;
        end
    end
endmodule

// File: tb/tb_bcd_display_scan.sv
// tb_bcd_display_scan: randomized bench for bcd_display_scan with a frame-level reference model
// (CLK_DIV=4, active-low outputs; honours LZ_BLANK_EN).
module tb_bcd_display_scan;
    localparam int CLK_DIV = 4;
    localparam int FRAME = 8 * CLK_DIV;
    localparam logic [6:0] PAT [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                        7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    logic clock = 1'b0, reset = 1'b1, load = 1'b0, neg_in = 1'b0;
    logic [31:0] bcd_in = '0;
    logic [7:0] an_out;
    logic [6:0] seg_out;
    logic dp_out, frame_done, bcd_err;
    int n_chk = 0, n_pass = 0, n_edge = 0;
    logic [32:0] m_act, m_pend;
    logic m_pv, m_err;
    logic [7:0] e_an;
    logic [6:0] e_seg;
    logic e_dp, e_fd;

    bcd_display_scan #(.CLK_DIV(CLK_DIV), .SEG_ACTIVE_LOW(1'b1)) dut (
        .clock(clock), .reset(reset), .load(load), .bcd_in(bcd_in), .neg_in(neg_in),
        .an_out(an_out), .seg_out(seg_out), .dp_out(dp_out),
        .frame_done(frame_done), .bcd_err(bcd_err)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (edge %0d)", tag, got, exp, n_edge);
    endtask

    // Expected outputs after one clock edge: the slot shown is set by elapsed cycles, the
    // value by what was latched at the last frame boundary.
    task automatic model_edge(input logic rs, input logic ld, input logic [31:0] b, input logic ng);
        int slot, msd;
        logic [3:0] d;
        logic [6:0] hi;
        logic dp;
        if (rs) begin
            n_edge = 0; m_act = '0; m_pend = '0; m_pv = 0; m_err = 0;
            e_an = 8'hFF; e_seg = 7'h7F; e_dp = 1; e_fd = 0;
            return;
        end
        slot = (n_edge / CLK_DIV) % 8;
        d = m_act[slot*4 +: 4];
        msd = 0;
        for (int k = 0; k < 8; k++) if (m_act[k*4 +: 4] != 0) msd = k;
        hi = d > 9 ? 7'h40 : PAT[d];
        dp = m_act[32] && slot == 7;
`ifdef LZ_BLANK_EN
        if (slot > msd) hi = (m_act[32] && slot == msd + 1) ? 7'h40 : 7'h00;
        dp = m_act[32] && slot == 7 && msd == 7;
`endif
        if (d > 9) m_err = 1;
        e_an = ~(8'd1 << slot);
        e_seg = ~hi;
        e_dp = ~dp;
        e_fd = (n_edge % FRAME) == FRAME - 1;
        if (e_fd && m_pv) begin m_act = m_pend; m_pv = 0; end
        if (ld) begin m_pend = {ng, b}; m_pv = 1; end
        n_edge++;
    endtask

    task automatic cyc(input logic ld, input logic [31:0] b, input logic ng);
        load = ld; bcd_in = b; neg_in = ng;
        @(posedge clock);
        model_edge(reset, ld, b, ng);
        @(negedge clock);
        check("an_out", 32'(an_out), 32'(e_an));
        check("seg_out", 32'(seg_out), 32'(e_seg));
        check("dp_out", 32'(dp_out), 32'(e_dp));
        check("frame_done", 32'(frame_done), 32'(e_fd));
        check("bcd_err", 32'(bcd_err), 32'(m_err));
        load = 0;
    endtask

    task automatic idle(input int k);
        repeat (k) cyc(0, '0, 0);
    endtask

    task automatic to_slot(input int s);
        while ((n_edge / CLK_DIV) % 8 != s) cyc(0, '0, 0);
    endtask

    function automatic logic [31:0] rand_bcd(input bit bad);
        logic [31:0] v;
        for (int k = 0; k < 8; k++) v[k*4 +: 4] = 4'(bad ? $urandom_range(15) : $urandom_range(9));
        return v & (32'hFFFF_FFFF >> (4 * $urandom_range(8)));
    endfunction

    initial begin
        repeat (3) cyc(0, '0, 0);
        reset = 0;
        idle(40);
        cyc(1, 32'h0000_1234, 0); idle(70);
        cyc(1, 32'h0000_0042, 1); idle(70);
        cyc(1, 32'h8765_4321, 1); idle(70);
        to_slot(3); cyc(1, 32'h1111_1111, 0); idle(70);
        cyc(1, 32'h5555_5555, 1); idle(5); cyc(1, 32'h0000_0789, 0); idle(70);
        to_slot(6); cyc(1, 32'h0000_0555, 0);
        while (n_edge % FRAME != FRAME - 1) cyc(0, '0, 0);
        cyc(1, 32'h0000_0001, 1); idle(70);
        cyc(1, 32'h0000_0000, 1); idle(70);
        repeat (1500) cyc($urandom_range(19) == 0, rand_bcd(0), 1'($urandom_range(1)));
        cyc(1, 32'h0000_000C, 0); idle(40);
        cyc(1, 32'h0000_0099, 0); idle(70);
        to_slot(4); cyc(1, 32'h0000_0321, 0); idle(3);
        reset = 1; cyc(0, '0, 0); reset = 0;
        idle(70);
        repeat (2000) begin
            reset = $urandom_range(299) == 0;
            cyc($urandom_range(19) == 0, rand_bcd($urandom_range(3) == 0), 1'($urandom_range(1)));
        end
        reset = 0;
        idle(40);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
